// File: rtl/pipe_sched.sv
// pipe_sched: round-robin scheduler sharing one pipe between two requesters,
// with tagged in-order results returned through a credit-protected response FIFO.
module pipe_sched #(
  parameter int DW = 16,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sched_en,
  input  logic          req0_valid,
  input  logic          req1_valid,
  output logic          req0_ready,
  output logic          req1_ready,
  input  logic [1:0]    req0_cf,
  input  logic [1:0]    req1_cf,
  input  logic [DW-1:0] req0_data0,
  input  logic [DW-1:0] req0_data1,
  input  logic [DW-1:0] req1_data0,
  input  logic [DW-1:0] req1_data1,
  output logic          p_en,
  output logic [1:0]    p_cf,
  output logic [DW-1:0] p_data0,
  output logic [DW-1:0] p_data1,
  input  logic [DW-1:0] p_res0,
  input  logic [DW-1:0] p_res1,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_id,
  output logic [DW-1:0] rsp_data0,
  output logic [DW-1:0] rsp_data1,
  output logic          busy
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_nx;
  logic last, v1, t0, t1, go, g1, push, pop;
  logic [AW-1:0] wr, rd;
  logic [AW:0] count;
  logic [AW+1:0] used;
  logic [DW-1:0] mem0 [DEPTH];
  logic [DW-1:0] mem1 [DEPTH];
  logic mem_id [DEPTH];
  // every op not yet popped holds a credit: FIFO entries, p_* stage and pipe stage
  assign used = (AW+2)'(count) + (AW+2)'(p_en) + (AW+2)'(v1);
  assign g1 = req1_valid && (!req0_valid || !last);
  assign go = state == RUN && (req0_valid || req1_valid) && used < (AW+2)'(DEPTH);
  assign req0_ready = go && !g1;
  assign req1_ready = go && g1;
  assign push = v1;
  assign rsp_valid = count != '0;
  assign pop = rsp_valid && rsp_ready;
  assign rsp_id = rsp_valid && mem_id[rd];
  assign rsp_data0 = rsp_valid ? mem0[rd] : '0;
  assign rsp_data1 = rsp_valid ? mem1[rd] : '0;
  assign busy = state != IDLE || p_en || v1 || rsp_valid;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = sched_en ? RUN : IDLE;
      RUN:     state_nx = sched_en ? RUN : DRAIN;
      DRAIN:   state_nx = sched_en ? RUN : (!p_en && !v1 && !rsp_valid) ? IDLE : DRAIN;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      last    <= 1'b1;
      p_en    <= 1'b0;
      p_cf    <= '0;
      p_data0 <= '0;
      p_data1 <= '0;
      t0      <= 1'b0;
      t1      <= 1'b0;
      v1      <= 1'b0;
      wr      <= '0;
      rd      <= '0;
      count   <= '0;
    end else begin
      state <= state_nx;
      p_en  <= go;
      v1    <= p_en;
      t1    <= t0;
      if (go) begin
        last    <= g1;
        t0      <= g1;
        p_cf    <= g1 ? req1_cf : req0_cf;
        p_data0 <= g1 ? req1_data0 : req0_data0;
        p_data1 <= g1 ? req1_data1 : req0_data1;
      end
      if (push) wr <= wr + AW'(1);
      if (pop) rd <= rd + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      mem0[wr]   <= p_res0;
      mem1[wr]   <= p_res1;
      mem_id[wr] <= t1;
    end
  end
endmodule

// File: tb/tb_pipe_sched.sv
// tb_pipe_sched: randomized + directed bench with a queue scoreboard and a
// transaction-level model of arbitration, credits and result latency.
module tb_pipe_sched;
  localparam int DW = 16;
  localparam int DEPTH = 4;
  logic clk = 0;
  logic rst_n = 0, sched_en = 0, req0_valid = 0, req1_valid = 0, rsp_ready = 0;
  logic [1:0] req0_cf = 0, req1_cf = 0;
  logic [DW-1:0] req0_data0 = 0, req0_data1 = 0, req1_data0 = 0, req1_data1 = 0;
  logic [DW-1:0] p_res0, p_res1;
  logic req0_ready, req1_ready, p_en, rsp_valid, rsp_id, busy;
  logic [1:0] p_cf;
  logic [DW-1:0] p_data0, p_data1, rsp_data0, rsp_data1;
  int checks = 0, errors = 0, cyc = 0, pops = 0;
  typedef struct {
    logic id;
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    int cyc;
  } exp_t;
  exp_t q[$];
  logic m_last = 1, m_run = 0, exp_rv, acc, w;
  exp_t e;

  pipe_sched #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .sched_en(sched_en),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_cf(req0_cf), .req1_cf(req1_cf),
    .req0_data0(req0_data0), .req0_data1(req0_data1),
    .req1_data0(req1_data0), .req1_data1(req1_data1),
    .p_en(p_en), .p_cf(p_cf), .p_data0(p_data0), .p_data1(p_data1),
    .p_res0(p_res0), .p_res1(p_res1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data0(rsp_data0), .rsp_data1(rsp_data1), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pf(input logic [DW-1:0] x, input logic [1:0] c);
    if (x == 0 || x == 16'hFFFF) return x;
    return DW'(32'(x) * 32'(c));
  endfunction

  function automatic logic [DW-1:0] rnd16();
    case ($urandom % 4)
      0: return 16'h0000;
      1: return 16'hFFFF;
      default: return DW'($urandom);
    endcase
  endfunction

  // the pipe: one register stage applying the scale rule
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_res0 <= '0;
      p_res1 <= '0;
    end else begin
      p_res0 <= pf(p_data0, p_cf);
      p_res1 <= pf(p_data1, p_cf);
    end
  end

  // scheduler is accepting iff sched_en was high at the last clock edge
  always @(posedge clk or negedge rst_n) m_run <= rst_n ? sched_en : 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      q.delete();
      m_last = 1;
    end else begin
      acc = m_run && (req0_valid || req1_valid) && q.size() < DEPTH;
      w = (req0_valid && req1_valid) ? !m_last : req1_valid;
      exp_rv = q.size() > 0 && q[0].cyc + 3 <= cyc;
      chk("rsp_valid", rsp_valid, exp_rv);
      if (rsp_valid && exp_rv) begin
        chk("rsp_id", rsp_id, q[0].id);
        chk("rsp_data0", rsp_data0, q[0].d0);
        chk("rsp_data1", rsp_data1, q[0].d1);
        if (rsp_ready) begin
          void'(q.pop_front());
          pops++;
        end
      end
      chk("req0_ready", req0_ready, acc && !w);
      chk("req1_ready", req1_ready, acc && w);
      if (acc) begin
        e.id = w;
        e.d0 = w ? pf(req1_data0, req1_cf) : pf(req0_data0, req0_cf);
        e.d1 = w ? pf(req1_data1, req1_cf) : pf(req0_data1, req0_cf);
        e.cyc = cyc;
        q.push_back(e);
        m_last = w;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit r, input logic [1:0] cf, input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    bit ok = 0;
    if (r) begin
      req1_cf = cf; req1_data0 = d0; req1_data1 = d1; req1_valid = 1;
    end else begin
      req0_cf = cf; req0_data0 = d0; req0_data1 = d1; req0_valid = 1;
    end
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = r ? req1_ready : req0_ready;
    end
    chk("issue_grant", ok, 1);
    step();
    req0_valid = 0;
    req1_valid = 0;
  endtask

  task automatic wait_idle(input string nm);
    bit ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      ok = !busy;
    end
    chk(nm, ok, 1);
    step();
  endtask

  task automatic rand_data();
    req0_cf = 2'($urandom); req1_cf = 2'($urandom);
    req0_data0 = rnd16(); req0_data1 = rnd16();
    req1_data0 = rnd16(); req1_data1 = rnd16();
  endtask

  initial begin
    int n;
    bit ok, prev;
    rsp_ready = 1;
    sched_en = 1;
    req0_cf = 2; req0_data0 = 16'h0003; req0_data1 = 16'h0010; req0_valid = 1;
    repeat (3) step();
    chk("rst_p_en", p_en, 0);
    chk("rst_p_cf", p_cf, 0);
    chk("rst_p_data0", p_data0, 0);
    chk("rst_p_data1", p_data1, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_data0", rsp_data0, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req0_ready", req0_ready, 0);
    rst_n = 1;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = req0_ready;
    end
    chk("t1_grant", ok, 1);
    step();
    req0_valid = 0;
    repeat (3) @(negedge clk);
    chk("t1_rsp_valid", rsp_valid, 1);
    chk("t1_rsp_id", rsp_id, 0);
    chk("t1_rsp_data0", rsp_data0, 16'h0006);
    chk("t1_rsp_data1", rsp_data1, 16'h0020);
    step();
    repeat (4) step();
    // both requesters continuously: one grant per cycle, alternating
    req0_valid = 1; req1_valid = 1; rand_data();
    prev = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("alt_ready", req0_ready ^ req1_ready, 1);
      if (i > 0) chk("alt_order", req1_ready, !prev);
      prev = req1_ready;
      step();
      rand_data();
    end
    req0_valid = 0; req1_valid = 0;
    repeat (6) step();
    issue(1, 3, 16'hFFFF, 16'h0000);
    repeat (3) @(negedge clk);
    chk("t3_id", rsp_id, 1);
    chk("t3_ffff", rsp_data0, 16'hFFFF);
    chk("t3_zero", rsp_data1, 16'h0000);
    step();
    issue(0, 2, 16'h8001, 16'h1234);
    repeat (3) @(negedge clk);
    chk("t3_ovf", rsp_data0, 16'h0002);
    chk("t3_d1", rsp_data1, 16'h2468);
    step();
    repeat (4) step();
    // backpressure: credits run out after exactly DEPTH accepts
    rsp_ready = 0; req0_valid = 1; n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      n += int'(req0_ready);
      step();
      rand_data();
    end
    chk("t4_accepts", n, DEPTH);
    rsp_ready = 1; n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      n += int'(req0_ready);
      step();
    end
    chk("t4_resume", n > 0, 1);
    req0_valid = 0;
    repeat (6) step();
    // drain: drop sched_en with two ops in flight
    req0_valid = 1; n = 0;
    for (int i = 0; i < 20 && n < 2; i++) begin
      @(negedge clk);
      n += int'(req0_ready);
      if (n < 2) step();
    end
    step();
    sched_en = 0; req0_valid = 0;
    step();
    req0_valid = 1;
    n = pops;
    wait_idle("drain_busy_fall");
    chk("drain_results", pops - n >= 2, 1);
    chk("drain_q_empty", q.size(), 0);
    @(negedge clk);
    chk("drain_no_ready", req0_ready, 0);
    chk("drain_idle", busy, 0);
    step();
    req0_valid = 0;
    // reset while the FIFO holds two entries and an op sits in the p_* stage
    sched_en = 1; rsp_ready = 0; req0_valid = 1; n = 0;
    for (int i = 0; i < 30 && n < DEPTH; i++) begin
      @(negedge clk);
      n += int'(req0_ready);
      if (n < DEPTH) step();
    end
    @(posedge clk);
    #1;
    chk("pre_rst_p_en", p_en, 1);
    chk("pre_rst_rsp_valid", rsp_valid, 1);
    #1 rst_n = 0;
    #1;
    chk("rst_mid_rsp_valid", rsp_valid, 0);
    chk("rst_mid_p_en", p_en, 0);
    chk("rst_mid_busy", busy, 0);
    req1_valid = 1; rsp_ready = 1;
    step();
    step();
    rst_n = 1;
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      ok = req0_ready | req1_ready;
      if (ok) chk("rst_first_grant_req0", req0_ready, 1);
    end
    chk("rst_regrant", ok, 1);
    step();
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      sched_en = ($urandom % 16) != 0;
      req0_valid = 1'($urandom);
      req1_valid = 1'($urandom);
      rsp_ready = ($urandom % 4) != 0;
      rand_data();
      step();
    end
    sched_en = 0; req0_valid = 0; req1_valid = 0; rsp_ready = 1;
    wait_idle("final_busy_fall");
    chk("final_q_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
